// File: rtl/arbitro_bus_datos_pkg.sv
`default_nettype none
// ============================================================================
// Module      : arbitro_bus_datos_pkg
// Description : Shared definitions for the two-master data-bus arbiter:
//               FSM state encoding, bus direction constants, master count,
//               default timeout and the owner-to-one-hot helper.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package arbitro_bus_datos_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } estado_t;

    localparam int unsigned c_NUM_MASTERS = 2;
    localparam int unsigned c_TIMEOUT_DEF = 15;
    localparam int unsigned c_CNT_W       = 8;

    localparam logic RW_WRITE = 1'b1;
    localparam logic RW_READ  = 1'b0;

    // Master index (0 = CPU core, 1 = peripheral/DMA) to one-hot vector.
    function automatic logic [c_NUM_MASTERS-1:0] one_hot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage
`default_nettype wire

// File: rtl/arbitro_bus_datos_if.sv
`default_nettype none
// ============================================================================
// Module      : arbitro_bus_datos_if
// Description : Request/grant and external data-bus signal bundle.
//               slave  : arbiter view (requests and bus responses in,
//                        grant/status and external bus strobes out).
//               master : requester/environment view (directions reversed).
// Ports       : i_Req, i_Addr, i_Data, i_RW, i_Dato_Bus, i_Ack,
//               o_Grant, o_Done, o_Err, o_Dato_Rd, o_Addres_Data_Bus,
//               o_DataOut_Bus, RW, o_Bus_Req
// Revision    : 1.0 - initial release
// ============================================================================
interface arbitro_bus_datos_if;
    import arbitro_bus_datos_pkg::*;

    logic [c_NUM_MASTERS-1:0] i_Req;
    logic [15:0]              i_Addr;
    logic [15:0]              i_Data;
    logic [c_NUM_MASTERS-1:0] i_RW;
    logic [7:0]               i_Dato_Bus;
    logic                     i_Ack;
    logic [c_NUM_MASTERS-1:0] o_Grant;
    logic [c_NUM_MASTERS-1:0] o_Done;
    logic [c_NUM_MASTERS-1:0] o_Err;
    logic [7:0]               o_Dato_Rd;
    logic [7:0]               o_Addres_Data_Bus;
    logic [7:0]               o_DataOut_Bus;
    logic                     RW;
    logic                     o_Bus_Req;

    modport slave (
        input  i_Req, i_Addr, i_Data, i_RW, i_Dato_Bus, i_Ack,
        output o_Grant, o_Done, o_Err, o_Dato_Rd, o_Addres_Data_Bus,
               o_DataOut_Bus, RW, o_Bus_Req
    );

    modport master (
        output i_Req, i_Addr, i_Data, i_RW, i_Dato_Bus, i_Ack,
        input  o_Grant, o_Done, o_Err, o_Dato_Rd, o_Addres_Data_Bus,
               o_DataOut_Bus, RW, o_Bus_Req
    );

endinterface
`default_nettype wire

// File: rtl/temporizador_bus.sv
`default_nettype none
// ============================================================================
// Module      : temporizador_bus
// Description : Access timeout counter. Cleared while i_clr is high, counts
//               while i_en is high. o_tc flags the cycle whose closing edge
//               would be the TIMEOUT-th counted edge, so the owner of the
//               counter can leave on exactly that edge.
// Ports       : i_Clk, i_Rst (async, active-high), i_clr, i_en, o_tc
// Revision    : 1.0 - initial release
// ============================================================================
module temporizador_bus
    import arbitro_bus_datos_pkg::*;
#(
    parameter int unsigned TIMEOUT = c_TIMEOUT_DEF
) (
    input  wire logic i_Clk,
    input  wire logic i_Rst,
    input  wire logic i_clr,
    input  wire logic i_en,
    output logic      o_tc
);

    logic [c_CNT_W-1:0] cnt_q;
    logic [c_CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_clr) begin
            cnt_d = '0;
        end else if (i_en) begin
            cnt_d = cnt_q + c_CNT_W'(1);
        end
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // cnt_q holds the number of edges already spent; the current one is next.
    assign o_tc = i_en && (cnt_q == c_CNT_W'(TIMEOUT - 1));

endmodule
`default_nettype wire

// File: rtl/arbitro_bus_datos.sv
`default_nettype none
// ============================================================================
// Module      : arbitro_bus_datos
// Description : Round-robin arbiter granting one of two masters access to an
//               external 8-bit data bus. IDLE -> ACCESS -> DONE, with an
//               access timeout. All outputs are registered.
// Ports       : i_Clk, i_Rst (async, active-high),
//               bus (arbitro_bus_datos_if.slave): requests, addresses, write
//               data, directions, grant/done/error, read data and the
//               external bus strobe/address/data/direction.
// Revision    : 1.0 - initial release
// ============================================================================
module arbitro_bus_datos
    import arbitro_bus_datos_pkg::*;
#(
    parameter int unsigned TIMEOUT = c_TIMEOUT_DEF
) (
    input  wire logic           i_Clk,
    input  wire logic           i_Rst,
    arbitro_bus_datos_if.slave  bus
);

    estado_t                  state_q, state_d;
    logic                     owner_q, owner_d;
    logic                     last_q, last_d;
    logic [c_NUM_MASTERS-1:0] grant_q, grant_d;
    logic [c_NUM_MASTERS-1:0] done_q, done_d;
    logic [c_NUM_MASTERS-1:0] err_q, err_d;
    logic [7:0]               dato_rd_q, dato_rd_d;
    logic [7:0]               addr_q, addr_d;
    logic [7:0]               dout_q, dout_d;
    logic                     rw_q, rw_d;
    logic                     bus_req_q, bus_req_d;

    logic w_win;
    logic w_en;
    logic w_tc;

    // On a tie the master that was not served last wins.
    assign w_win = (&bus.i_Req) ? ~last_q : bus.i_Req[1];
    assign w_en  = (state_q == ST_ACCESS);

    temporizador_bus #(
        .TIMEOUT (TIMEOUT)
    ) u_temporizador (
        .i_Clk (i_Clk),
        .i_Rst (i_Rst),
        .i_clr (~w_en),
        .i_en  (w_en),
        .o_tc  (w_tc)
    );

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        grant_d   = grant_q;
        done_d    = '0;
        err_d     = '0;
        dato_rd_d = dato_rd_q;
        addr_d    = addr_q;
        dout_d    = dout_q;
        rw_d      = rw_q;
        bus_req_d = bus_req_q;

        unique case (state_q)
            ST_IDLE: begin
                if (|bus.i_Req) begin
                    state_d   = ST_ACCESS;
                    owner_d   = w_win;
                    grant_d   = one_hot(w_win);
                    addr_d    = w_win ? bus.i_Addr[15:8] : bus.i_Addr[7:0];
                    dout_d    = w_win ? bus.i_Data[15:8] : bus.i_Data[7:0];
                    rw_d      = bus.i_RW[w_win];
                    bus_req_d = 1'b1;
                end
            end
            ST_ACCESS: begin
                // An acknowledge on the terminal-count cycle still completes
                // normally; the error is only raised when no ack arrived.
                if (bus.i_Ack || w_tc) begin
                    state_d   = ST_DONE;
                    done_d    = one_hot(owner_q);
                    if (!bus.i_Ack) begin
                        err_d = one_hot(owner_q);
                    end
                    if (bus.i_Ack && (rw_q != RW_WRITE)) begin
                        dato_rd_d = bus.i_Dato_Bus;
                    end
                    grant_d   = '0;
                    bus_req_d = 1'b0;
                    rw_d      = RW_READ;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                last_d  = owner_q;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state_q   <= ST_IDLE;
            owner_q   <= 1'b0;
            last_q    <= 1'b1;
            grant_q   <= '0;
            done_q    <= '0;
            err_q     <= '0;
            dato_rd_q <= '0;
            addr_q    <= '0;
            dout_q    <= '0;
            rw_q      <= 1'b0;
            bus_req_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            grant_q   <= grant_d;
            done_q    <= done_d;
            err_q     <= err_d;
            dato_rd_q <= dato_rd_d;
            addr_q    <= addr_d;
            dout_q    <= dout_d;
            rw_q      <= rw_d;
            bus_req_q <= bus_req_d;
        end
    end

    assign bus.o_Grant           = grant_q;
    assign bus.o_Done            = done_q;
    assign bus.o_Err             = err_q;
    assign bus.o_Dato_Rd         = dato_rd_q;
    assign bus.o_Addres_Data_Bus = addr_q;
    assign bus.o_DataOut_Bus     = dout_q;
    assign bus.RW                = rw_q;
    assign bus.o_Bus_Req         = bus_req_q;

endmodule
`default_nettype wire

// File: tb/tb_arbitro_bus_datos.sv
`default_nettype none
// ============================================================================
// Module      : tb_arbitro_bus_datos
// Description : Self-checking bench for arbitro_bus_datos. A transaction-level
//               reference model predicts every registered output; a compare
//               process checks all outputs each falling edge, and directed
//               sequences pin the model with literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_arbitro_bus_datos;

    localparam int TMO = 15;

    logic clk = 1'b0;
    logic rst = 1'b0;

    arbitro_bus_datos_if bus_if ();

    arbitro_bus_datos #(
        .TIMEOUT (TMO)
    ) dut (
        .i_Clk (clk),
        .i_Rst (rst),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    // ---------------- reference model (transaction view) ----------------
    bit         m_busy;      // a transaction owns the bus
    bit         m_finished;  // the completion cycle is being shown
    int         m_owner;
    int         m_last;
    int         m_waited;    // edges spent waiting for the acknowledge
    logic [1:0] e_grant, e_done, e_err;
    logic [7:0] e_dato, e_addr, e_dout;
    logic       e_rw, e_breq;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_finished = 0; m_owner = 0; m_last = 1; m_waited = 0;
        e_grant = 0; e_done = 0; e_err = 0; e_dato = 0; e_addr = 0; e_dout = 0;
        e_rw = 0; e_breq = 0;
    endtask

    task automatic model_step(input logic [1:0] req, input logic [15:0] addr,
                              input logic [15:0] data, input logic [1:0] rw,
                              input logic ack, input logic [7:0] dato);
        e_done = 0;
        e_err  = 0;
        if (m_finished) begin
            m_finished = 0;
            m_last     = m_owner;
        end else if (!m_busy) begin
            if (req != 0) begin
                if (req == 2'b11) m_owner = 1 - m_last;
                else              m_owner = req[1] ? 1 : 0;
                m_busy   = 1;
                m_waited = 0;
                e_grant  = 2'(1 << m_owner);
                e_addr   = addr[8*m_owner +: 8];
                e_dout   = data[8*m_owner +: 8];
                e_rw     = rw[m_owner];
                e_breq   = 1;
            end
        end else begin
            m_waited++;
            if (ack || m_waited == TMO) begin
                m_busy     = 0;
                m_finished = 1;
                e_done     = 2'(1 << m_owner);
                if (!ack) e_err = e_done;
                if (ack && e_rw == 1'b0) e_dato = dato;
                e_grant = 0;
                e_breq  = 0;
                e_rw    = 0;
            end
        end
    endtask

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            chk("grant",   32'(bus_if.o_Grant),           32'(e_grant));
            chk("done",    32'(bus_if.o_Done),            32'(e_done));
            chk("err",     32'(bus_if.o_Err),             32'(e_err));
            chk("dato_rd", 32'(bus_if.o_Dato_Rd),         32'(e_dato));
            chk("addr",    32'(bus_if.o_Addres_Data_Bus), 32'(e_addr));
            chk("dout",    32'(bus_if.o_DataOut_Bus),     32'(e_dout));
            chk("rw",      32'(bus_if.RW),                32'(e_rw));
            chk("bus_req", 32'(bus_if.o_Bus_Req),         32'(e_breq));
        end
    end

    // ---------------- stimulus helpers ----------------
    // Called at a falling edge; drives inputs, steps the model on the rising
    // edge and returns at the next falling edge.
    task automatic tick(input logic [1:0] req, input logic [15:0] addr,
                        input logic [15:0] data, input logic [1:0] rw,
                        input logic ack, input logic [7:0] dato);
        bus_if.i_Req      = req;
        bus_if.i_Addr     = addr;
        bus_if.i_Data     = data;
        bus_if.i_RW       = rw;
        bus_if.i_Ack      = ack;
        bus_if.i_Dato_Bus = dato;
        @(posedge clk);
        if (rst) model_reset();
        else     model_step(req, addr, data, rw, ack, dato);
        @(negedge clk);
    endtask

    task automatic idle_tick();
        tick(2'b00, 16'h0000, 16'h0000, 2'b00, 1'b0, 8'h00);
    endtask

    task automatic async_reset();
        #2 rst = 1'b1;
        model_reset();
        #1;
        chk("reset_async_outputs",
            32'({bus_if.o_Grant, bus_if.o_Done, bus_if.o_Err, bus_if.o_Dato_Rd,
                 bus_if.o_Addres_Data_Bus, bus_if.o_DataOut_Bus, bus_if.RW,
                 bus_if.o_Bus_Req}), 32'h0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    logic [1:0] rr_exp [12];
    bit saw_pulse;

    initial begin
        rr_exp = '{2'b01, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00,
                   2'b01, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00};
        bus_if.i_Req = 0; bus_if.i_Addr = 0; bus_if.i_Data = 0;
        bus_if.i_RW = 0; bus_if.i_Ack = 0; bus_if.i_Dato_Bus = 0;
        model_reset();
        #1 rst = 1'b1;
        @(negedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        chk("reset_grant",   32'(bus_if.o_Grant),   32'h0);
        chk("reset_dato_rd", 32'(bus_if.o_Dato_Rd), 32'h0);
        chk("reset_bus_req", 32'(bus_if.o_Bus_Req), 32'h0);
        rst = 1'b0;
        idle_tick();

        // M0 write
        tick(2'b01, 16'h003C, 16'h00A5, 2'b01, 1'b0, 8'h00);
        chk("m0w_addr",  32'(bus_if.o_Addres_Data_Bus), 32'h3C);
        chk("m0w_dout",  32'(bus_if.o_DataOut_Bus),     32'hA5);
        chk("m0w_rw",    32'(bus_if.RW),                32'h1);
        chk("m0w_grant", 32'(bus_if.o_Grant),           32'h1);
        chk("m0w_breq",  32'(bus_if.o_Bus_Req),         32'h1);
        tick(2'b00, 16'h0000, 16'h0000, 2'b00, 1'b1, 8'hEE);
        chk("m0w_done",  32'(bus_if.o_Done),    32'h1);
        chk("m0w_err",   32'(bus_if.o_Err),     32'h0);
        chk("m0w_dato",  32'(bus_if.o_Dato_Rd), 32'h0);
        chk("m0w_grant0",32'(bus_if.o_Grant),   32'h0);
        idle_tick();
        chk("m0w_done_pulse", 32'(bus_if.o_Done), 32'h0);

        // M1 read
        tick(2'b10, 16'h8000, 16'h0000, 2'b00, 1'b0, 8'h00);
        chk("m1r_addr",  32'(bus_if.o_Addres_Data_Bus), 32'h80);
        chk("m1r_rw",    32'(bus_if.RW),                32'h0);
        chk("m1r_grant", 32'(bus_if.o_Grant),           32'h2);
        tick(2'b00, 16'h0000, 16'h0000, 2'b00, 1'b1, 8'h5A);
        chk("m1r_dato",  32'(bus_if.o_Dato_Rd), 32'h5A);
        chk("m1r_done",  32'(bus_if.o_Done),    32'h2);
        idle_tick();

        // Round robin with both masters requesting from reset
        async_reset();
        for (int i = 0; i < 12; i++) begin
            tick(2'b11, 16'h2211, 16'h4433, 2'b00, 1'b1, 8'($urandom));
            chk($sformatf("rr_grant_%0d", i), 32'(bus_if.o_Grant), 32'(rr_exp[i]));
        end

        // Timeout with no acknowledge
        async_reset();
        tick(2'b01, 16'h0011, 16'h0000, 2'b00, 1'b0, 8'h00);
        tick(2'b00, 16'h0000, 16'h0000, 2'b00, 1'b1, 8'h77);
        idle_tick();
        tick(2'b01, 16'h0042, 16'h0000, 2'b00, 1'b0, 8'h99);
        for (int i = 1; i < TMO; i++) begin
            tick(2'b01, 16'h0042, 16'h0000, 2'b00, 1'b0, 8'($urandom));
            chk($sformatf("tmo_wait_%0d", i), 32'(bus_if.o_Done), 32'h0);
        end
        tick(2'b00, 16'h0000, 16'h0000, 2'b00, 1'b0, 8'hC3);
        chk("tmo_done", 32'(bus_if.o_Done),    32'h1);
        chk("tmo_err",  32'(bus_if.o_Err),     32'h1);
        chk("tmo_breq", 32'(bus_if.o_Bus_Req), 32'h0);
        chk("tmo_dato", 32'(bus_if.o_Dato_Rd), 32'h77);
        idle_tick();

        // Acknowledge on the terminal-count cycle
        async_reset();
        tick(2'b01, 16'h0005, 16'h0000, 2'b00, 1'b0, 8'h00);
        for (int i = 1; i < TMO; i++) idle_tick();
        tick(2'b00, 16'h0000, 16'h0000, 2'b00, 1'b1, 8'h03);
        chk("tc_ack_done", 32'(bus_if.o_Done),    32'h1);
        chk("tc_ack_err",  32'(bus_if.o_Err),     32'h0);
        chk("tc_ack_dato", 32'(bus_if.o_Dato_Rd), 32'h03);
        idle_tick();

        // Reset in the middle of an access
        tick(2'b10, 16'h9900, 16'h1200, 2'b10, 1'b0, 8'h00);
        idle_tick();
        async_reset();
        saw_pulse = 0;
        for (int i = 0; i < 20; i++) begin
            idle_tick();
            if (bus_if.o_Done != 0 || bus_if.o_Err != 0) saw_pulse = 1;
        end
        chk("rst_abort_no_pulse", 32'(saw_pulse), 32'h0);

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 599) == 0) begin
                async_reset();
            end else begin
                tick(2'($urandom), 16'($urandom), 16'($urandom), 2'($urandom),
                     ($urandom_range(0, 3) == 0), 8'($urandom));
            end
        end

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
